cdc_handshake_tx: RTL and testbench

//  Source side of a 4-phase req/ack clock-domain crossing. Accepts a data word on a local

---
 rtl/cdc_handshake_tx_if.sv | 25 ++
 rtl/cdc_handshake_tx.sv | 111 +++++++++++
 tb/tb_cdc_handshake_tx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_handshake_tx_if.sv
// Local valid/ready source port and remote req/ack pair of the CDC transmitter.
// "master" is the transmitter side, "slave" is the source/receiver environment.
interface cdc_handshake_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_req;
    logic              ack_in;
    logic              busy;
    logic              done;
    logic              timeout_err;

    modport master (
        input  s_data, s_valid, ack_in,
        output s_ready, tx_data, tx_req, busy, done, timeout_err
    );

    modport slave (
        output s_data, s_valid, ack_in,
        input  s_ready, tx_data, tx_req, busy, done, timeout_err
    );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack crossing: latches a word, raises tx_req and
// waits for the synchronized ack to rise and fall before taking the next word.
module cdc_handshake_tx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cdc_handshake_tx_if.master    bus
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, ACK_WAIT} state_t;

    state_t            state, state_nxt;
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] ack_sync;
    logic              ack_s, ack_s_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] tx_data_q, tx_data_nxt;
    logic              tx_req_q, tx_req_nxt;
    logic              s_ready_q, s_ready_nxt;
    logic              done_q, done_nxt;
    logic              err_q, err_nxt;
    logic              aborted, aborted_nxt;
    logic              accept;

    // ack_s_nxt is what the last sync stage will hold after this edge, so
    // s_ready can be registered without a cycle of stale readiness.
    assign ack_s     = ack_sync[SYNC_STAGES-1];
    assign ack_s_nxt = ack_sync[SYNC_STAGES-2];
    assign accept    = bus.s_valid && s_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync  <= '0;
            state     <= IDLE;
            cnt       <= '0;
            tx_data_q <= '0;
            tx_req_q  <= 1'b0;
            s_ready_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            ack_sync  <= {ack_sync[SYNC_STAGES-2:0], bus.ack_in};
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            tx_data_q <= tx_data_nxt;
            tx_req_q  <= tx_req_nxt;
            s_ready_q <= s_ready_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
            aborted   <= aborted_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        tx_data_nxt = tx_data_q;
        tx_req_nxt  = tx_req_q;
        done_nxt    = 1'b0;
        err_nxt     = err_q;
        aborted_nxt = aborted;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt   = REQ;
                    tx_data_nxt = bus.s_data;
                    tx_req_nxt  = 1'b1;
                    cnt_nxt     = '0;
                    aborted_nxt = 1'b0;
                end
            end
            REQ: begin
                // A real ack on the timeout edge wins: the transfer completed.
                if (ack_s) begin
                    state_nxt  = ACK_WAIT;
                    tx_req_nxt = 1'b0;
                end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                    state_nxt   = ACK_WAIT;
                    tx_req_nxt  = 1'b0;
                    err_nxt     = 1'b1;
                    aborted_nxt = 1'b1;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ACK_WAIT: begin
                if (!ack_s) begin
                    state_nxt = IDLE;
                    done_nxt  = !aborted;
                end
            end
            default: begin
                state_nxt  = IDLE;
                tx_req_nxt = 1'b0;
            end
        endcase
        s_ready_nxt = (state_nxt == IDLE) && !ack_s_nxt;
    end

    assign bus.s_ready     = s_ready_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_req      = tx_req_q;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: remote receiver model plus a data scoreboard
// checked whenever tx_req rises.
module tb_cdc_handshake_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic remote_en = 1'b0;
    logic ack_model = 1'b0;
    logic ack_manual = 1'b0;
    int   rcnt = 0;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    logic [7:0] sb_q[$];
    logic [7:0] held = '0;
    logic       prev_req = 1'b0;
    logic       prev_done = 1'b0;

    cdc_handshake_tx_if #(.DATA_W(8)) bus_if ();

    cdc_handshake_tx #(.DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.master)
    );

    always #5 clk = ~clk;

    assign bus_if.ack_in = remote_en ? ack_model : ack_manual;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Remote receiver: raises ack a few cycles after req, drops it once req falls.
    always @(negedge clk) begin
        if (!remote_en) begin
            ack_model = 1'b0;
            rcnt = 0;
        end else if (bus_if.tx_req) begin
            if (rcnt == 3) ack_model = 1'b1;
            else rcnt++;
        end else begin
            ack_model = 1'b0;
            rcnt = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            prev_req  = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (bus_if.tx_req && !prev_req) begin
                chk("sb_depth", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    held = sb_q.pop_front();
                    chk("tx_data", 32'(bus_if.tx_data), 32'(held));
                end
            end else if (bus_if.tx_req) begin
                chk("data_stable", 32'(bus_if.tx_data), 32'(held));
            end
            if (bus_if.done) begin
                chk("done_pulse", 32'(prev_done), 0);
                done_cnt++;
            end
            prev_req  = bus_if.tx_req;
            prev_done = bus_if.done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] w);
        bit ok = 0;
        @(negedge clk);
        bus_if.s_data  = w;
        bus_if.s_valid = 1'b1;
        sb_q.push_back(w);
        for (int i = 0; i < 60 && !ok; i++) begin
            if (bus_if.s_ready) begin
                @(posedge clk);
                ok = 1;
            end else begin
                @(negedge clk);
            end
        end
        #2;
        chk("accept", 32'(ok), 1);
        if (ok) chk("req_rise", 32'(bus_if.tx_req), 1);
    endtask

    task automatic wait_dones(input int n);
        int target = done_cnt + n;
        for (int i = 0; i < 200 && done_cnt < target; i++) tick();
        chk("done_count", done_cnt, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(bus_if.tx_req), 0);
        chk({tag, "_rdy"},   32'(bus_if.s_ready), 0);
        chk({tag, "_busy"},  32'(bus_if.busy), 0);
        chk({tag, "_done"},  32'(bus_if.done), 0);
        chk({tag, "_err"},   32'(bus_if.timeout_err), 0);
        chk({tag, "_data"},  32'(bus_if.tx_data), 0);
    endtask

    initial begin
        int dc;
        bus_if.s_data  = '0;
        bus_if.s_valid = 1'b0;

        // 1: async reset asserted mid-clock, then release
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", 32'(bus_if.s_ready), 1);
        chk("rst_busy", 32'(bus_if.busy), 0);

        // 2: single transfer with ack latency
        remote_en = 1'b1;
        send(8'hA5);
        bus_if.s_valid = 1'b0;
        for (int i = 0; i < 20 && bus_if.ack_in !== 1'b1; i++) tick();
        chk("ack_seen", 32'(bus_if.ack_in), 1);
        chk("req_m0", 32'(bus_if.tx_req), 1);
        tick();
        chk("req_m1", 32'(bus_if.tx_req), 1);
        tick();
        chk("req_m2", 32'(bus_if.tx_req), 0);
        wait_dones(1);
        chk("x2_ready", 32'(bus_if.s_ready), 1);
        chk("x2_err", 32'(bus_if.timeout_err), 0);

        // 3: back-to-back with s_valid held
        send(8'h01);
        send(8'h02);
        bus_if.s_valid = 1'b0;
        wait_dones(1);
        tick();
        chk("b2b_idle", 32'(bus_if.busy), 0);

        // 4: timeout with no ack, then a normal transfer
        remote_en = 1'b0;
        send(8'h99);
        bus_if.s_valid = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("to_req_hold", 32'(bus_if.tx_req), 1);
        end
        dc = done_cnt;
        tick();
        chk("to_req_fall", 32'(bus_if.tx_req), 0);
        chk("to_err", 32'(bus_if.timeout_err), 1);
        repeat (3) tick();
        chk("to_no_done", done_cnt, dc);
        chk("to_ready", 32'(bus_if.s_ready), 1);
        remote_en = 1'b1;
        send(8'h3C);
        bus_if.s_valid = 1'b0;
        wait_dones(1);
        chk("to_err_sticky", 32'(bus_if.timeout_err), 1);

        // 5: reset while in REQ
        send(8'h55);
        bus_if.s_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mid_ready", 32'(bus_if.s_ready), 1);
        send(8'h77);
        bus_if.s_valid = 1'b0;
        wait_dones(1);

        // 6: stuck ack while idle
        remote_en = 1'b0;
        @(negedge clk);
        ack_manual = 1'b1;
        repeat (3) tick();
        chk("stuck_rdy", 32'(bus_if.s_ready), 0);
        @(negedge clk);
        bus_if.s_data  = 8'h5A;
        bus_if.s_valid = 1'b1;
        sb_q.push_back(8'h5A);
        repeat (4) begin
            tick();
            chk("stuck_noreq", 32'(bus_if.tx_req), 0);
            chk("stuck_busy", 32'(bus_if.busy), 0);
        end
        @(negedge clk);
        ack_manual = 1'b0;
        tick();
        chk("stuck_rdy_k", 32'(bus_if.s_ready), 0);
        tick();
        chk("stuck_rdy_k1", 32'(bus_if.s_ready), 1);
        tick();
        chk("stuck_req", 32'(bus_if.tx_req), 1);
        bus_if.s_valid = 1'b0;
        remote_en = 1'b1;
        wait_dones(1);

        repeat (3) tick();
        chk("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
